// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg: shared state, opcode and control-field encodings for the multicycle control unit
package riscv_ctrl_pkg;
  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR,
    EXECI, ALUWB, BRANCH, JAL, JALR, JALRWB, TRAP
  } state_t;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_PASSB = 3'b100;
  localparam logic [2:0] ALU_SLT   = 3'b101;
  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;
  localparam logic [1:0] RES_ALUOUT    = 2'b00;
  localparam logic [1:0] RES_DATA      = 2'b01;
  localparam logic [1:0] RES_ALURESULT = 2'b10;
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RD1   = 2'b10;
  localparam logic [1:0] SRCB_RD2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;
  localparam logic [1:0] CLS_R   = 2'd0;
  localparam logic [1:0] CLS_I   = 2'd1;
  localparam logic [1:0] CLS_LUI = 2'd2;
endpackage

// File: rtl/alu_decoder.sv
// alu_decoder: maps opcode class, funct3 and funct7[5] to an ALU operation
// Ports: cls (CLS_R/CLS_I/CLS_LUI), funct3, funct7_5 in; alu_ctrl, illegal (unsupported funct3) out
module alu_decoder
  import riscv_ctrl_pkg::*;
(
  input  logic [1:0] cls,
  input  logic [2:0] funct3,
  input  logic       funct7_5,
  output logic [2:0] alu_ctrl,
  output logic       illegal
);
  always_comb begin
    alu_ctrl = ALU_ADD;
    illegal  = 1'b0;
    if (cls == CLS_LUI) alu_ctrl = ALU_PASSB;
    else case (funct3)
      3'b000:  alu_ctrl = (cls == CLS_R && funct7_5) ? ALU_SUB : ALU_ADD;
      3'b110:  alu_ctrl = ALU_OR;
      3'b111:  alu_ctrl = ALU_AND;
      3'b010:  alu_ctrl = ALU_SLT;
      default: illegal = 1'b1;
    endcase
  end
endmodule

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit: RV32I multicycle control FSM for a shared-ALU, single-memory datapath
// Ports: clk, rst_n (sync, active low), Instr, Zero, alu_lt, mem_ready in;
//        PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, RegWrite,
//        ALUControl, ImmSrc, instr_done, illegal_instr out (all combinational from state + inputs)
// Optional: define BRANCH_EXT_EN to add bne/blt/bge to the beq-only branch decode.
module multicycle_control_unit
  import riscv_ctrl_pkg::*;
#(
  parameter int ALUCTRL_W     = 3,
  parameter int IMMSRC_W      = 3,
  parameter bit MEM_HANDSHAKE = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          Instr,
  input  logic                 Zero,
  input  logic                 alu_lt,
  input  logic                 mem_ready,
  output logic                 PCWrite,
  output logic                 AdrSrc,
  output logic                 MemWrite,
  output logic                 IRWrite,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic                 RegWrite,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic [IMMSRC_W-1:0]  ImmSrc,
  output logic                 instr_done,
  output logic                 illegal_instr
);
  state_t state, next;
  logic [6:0] op;
  logic [2:0] f3, alu_c, alu_ctrl, imm;
  logic [1:0] cls;
  logic rdy, alu_ill, br_take, br_ill, pcw, irw, memw, rw;
  logic unused_bits;
  assign op  = Instr[6:0];
  assign f3  = Instr[14:12];
  assign rdy = MEM_HANDSHAKE ? mem_ready : 1'b1;
  assign cls = state == EXECR ? CLS_R : (op == OP_LUI ? CLS_LUI : CLS_I);
  alu_decoder u_alu_decoder (
    .cls      (cls),
    .funct3   (f3),
    .funct7_5 (Instr[30]),
    .alu_ctrl (alu_c),
    .illegal  (alu_ill)
  );
`ifdef BRANCH_EXT_EN
  always_comb begin
    br_take = 1'b0;
    br_ill  = 1'b0;
    case (f3)
      3'b000:  br_take = Zero;
      3'b001:  br_take = ~Zero;
      3'b100:  br_take = alu_lt;
      3'b101:  br_take = ~alu_lt;
      default: br_ill = 1'b1;
    endcase
  end
  assign unused_bits = ^{Instr[31], Instr[29:15], Instr[11:7]};
`else
  assign br_take     = Zero;
  assign br_ill      = f3 != 3'b000;
  assign unused_bits = ^{Instr[31], Instr[29:15], Instr[11:7], alu_lt};
`endif
  always_ff @(posedge clk)
    state <= !rst_n ? FETCH : next;
  always_comb begin
    next       = state;
    pcw        = 1'b0;
    irw        = 1'b0;
    memw       = 1'b0;
    rw         = 1'b0;
    AdrSrc     = 1'b0;
    ResultSrc  = RES_ALUOUT;
    ALUSrcA    = SRCA_PC;
    ALUSrcB    = SRCB_RD2;
    alu_ctrl   = ALU_ADD;
    imm        = IMM_I;
    instr_done = 1'b0;
    case (state)
      FETCH: begin
        ALUSrcB   = SRCB_FOUR;
        ResultSrc = RES_ALURESULT;
        irw       = rdy;
        pcw       = rdy;
        next      = rdy ? DECODE : FETCH;
      end
      // Branch/jump target is precomputed into ALUOut from OldPC + ImmExt.
      DECODE: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_IMM;
        imm     = op == OP_STORE ? IMM_S : op == OP_BRANCH ? IMM_B :
                  op == OP_JAL ? IMM_J : op == OP_LUI ? IMM_U : IMM_I;
        next    = (op == OP_LOAD || op == OP_STORE) ? MEMADR :
                  op == OP_R ? EXECR :
                  (op == OP_I || op == OP_LUI) ? EXECI :
                  op == OP_BRANCH ? BRANCH :
                  op == OP_JAL ? JAL :
                  op == OP_JALR ? JALR : TRAP;
      end
      MEMADR: begin
        ALUSrcA = SRCA_RD1;
        ALUSrcB = SRCB_IMM;
        imm     = op == OP_STORE ? IMM_S : IMM_I;
        next    = op == OP_STORE ? MEMWRITE : MEMREAD;
      end
      MEMREAD: begin
        AdrSrc = 1'b1;
        next   = rdy ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        ResultSrc  = RES_DATA;
        rw         = 1'b1;
        instr_done = 1'b1;
        next       = FETCH;
      end
      MEMWRITE: begin
        AdrSrc     = 1'b1;
        memw       = 1'b1;
        instr_done = rdy;
        next       = rdy ? FETCH : MEMWRITE;
      end
      EXECR: begin
        ALUSrcA  = SRCA_RD1;
        alu_ctrl = alu_c;
        next     = alu_ill ? TRAP : ALUWB;
      end
      EXECI: begin
        ALUSrcA  = SRCA_RD1;
        ALUSrcB  = SRCB_IMM;
        imm      = op == OP_LUI ? IMM_U : IMM_I;
        alu_ctrl = alu_c;
        next     = alu_ill ? TRAP : ALUWB;
      end
      ALUWB: begin
        rw         = 1'b1;
        instr_done = 1'b1;
        next       = FETCH;
      end
      // An unsupported branch condition traps without touching the PC or retiring.
      BRANCH: begin
        ALUSrcA    = SRCA_RD1;
        alu_ctrl   = ALU_SUB;
        imm        = IMM_B;
        pcw        = br_take & ~br_ill;
        instr_done = ~br_ill;
        next       = br_ill ? TRAP : FETCH;
      end
      JAL: begin
        ALUSrcA = SRCA_OLDPC;
        ALUSrcB = SRCB_FOUR;
        pcw     = 1'b1;
        next    = ALUWB;
      end
      JALR: begin
        ALUSrcA   = SRCA_RD1;
        ALUSrcB   = SRCB_IMM;
        ResultSrc = RES_ALURESULT;
        pcw       = 1'b1;
        next      = JALRWB;
      end
      JALRWB: begin
        ALUSrcA    = SRCA_OLDPC;
        ALUSrcB    = SRCB_FOUR;
        ResultSrc  = RES_ALURESULT;
        rw         = 1'b1;
        instr_done = 1'b1;
        next       = FETCH;
      end
      TRAP:    next = TRAP;
      default: next = FETCH;
    endcase
  end
  assign PCWrite       = pcw & rst_n;
  assign IRWrite       = irw & rst_n;
  assign MemWrite      = memw & rst_n;
  assign RegWrite      = rw & rst_n;
  assign ALUControl    = ALUCTRL_W'(alu_ctrl);
  assign ImmSrc        = IMMSRC_W'(imm);
  assign illegal_instr = state == TRAP;
endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit: per-instruction step-sequence model versus the multicycle control unit
module tb_multicycle_control_unit;
  typedef enum {X, F, D, MA, MR, MWB, MW, XR, XI, AWB, BR, JL, JR, JRWB, TR} step_t;
  typedef struct packed {
    logic pcw; logic adr; logic memw; logic irw; logic [1:0] res; logic [1:0] sa;
    logic [1:0] sb; logic rw; logic [2:0] alu; logic [2:0] imm; logic done; logic ill;
  } ctl_t;
  typedef struct {int cyc; ctl_t e; ctl_t m;} lit_t;
  logic clk = 0, rst_n = 0, Zero = 0, alu_lt = 0, mem_ready = 0;
  logic [31:0] Instr = 0;
  logic PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, instr_done, illegal_instr;
  logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
  logic [2:0] ALUControl, ImmSrc;
  ctl_t act, exp_c, msk_c, lit_e, lit_m;
  step_t cur = X;
  bit exp_valid = 0, rnd = 0, rst_req = 0;
  int zf = -1, hold = 0, tests = 0, fails = 0;
  lit_t lits[$];
  always #5 clk = ~clk;
  multicycle_control_unit dut (
    .clk(clk), .rst_n(rst_n), .Instr(Instr), .Zero(Zero), .alu_lt(alu_lt), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .AdrSrc(AdrSrc), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegWrite(RegWrite),
    .ALUControl(ALUControl), .ImmSrc(ImmSrc), .instr_done(instr_done), .illegal_instr(illegal_instr)
  );
  assign act = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB, RegWrite,
                ALUControl, ImmSrc, instr_done, illegal_instr};
  always @(negedge clk) if (exp_valid) begin
    tests++;
    if (((act ^ exp_c) & msk_c) != '0) begin
      fails++;
      $display("FAIL model step=%s instr=%h got=%h want=%h mask=%h", cur.name(), Instr, act, exp_c, msk_c);
    end
    if (lit_m != '0) begin
      tests++;
      if (((act ^ lit_e) & lit_m) != '0) begin
        fails++;
        $display("FAIL literal step=%s instr=%h got=%h want=%h mask=%h", cur.name(), Instr, act, lit_e, lit_m);
      end
    end
  end
  function automatic bit alu_ok(input logic [2:0] f3);
    return f3 == 3'd0 || f3 == 3'd2 || f3 == 3'd6 || f3 == 3'd7;
  endfunction
  function automatic logic [2:0] alu_code(input logic [2:0] f3, input logic neg);
    case (f3)
      3'd0:    return neg ? 3'd1 : 3'd0;
      3'd6:    return 3'd3;
      3'd7:    return 3'd2;
      default: return 3'd5;
    endcase
  endfunction
  function automatic bit br_ok(input logic [2:0] f3);
`ifdef BRANCH_EXT_EN
    return f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd4 || f3 == 3'd5;
`else
    return f3 == 3'd0;
`endif
  endfunction
  function automatic logic taken(input logic [2:0] f3, input logic z, input logic lt);
    case (f3)
      3'd0:    return z;
      3'd1:    return !z;
      3'd4:    return lt;
      default: return !lt;
    endcase
  endfunction
  function automatic logic [2:0] imm_of(input logic [6:0] op);
    case (op)
      7'h23:   return 3'd1;
      7'h63:   return 3'd2;
      7'h6f:   return 3'd3;
      7'h37:   return 3'd4;
      default: return 3'd0;
    endcase
  endfunction
  function automatic void model(input step_t s, input logic [31:0] ins, input logic z, input logic lt,
                                input logic rdy, input logic rst, output ctl_t e, output ctl_t m);
    logic [6:0] op = ins[6:0];
    logic [2:0] f3 = ins[14:12];
    e = '0;
    m = '1;
    case (s)
      X:    begin m = '0; m.pcw = 1; m.irw = 1; m.memw = 1; m.rw = 1; end
      F:    begin e.sb = 2; e.res = 2; e.pcw = rdy; e.irw = rdy; end
      D:    begin e.sa = 1; e.sb = 1; e.imm = imm_of(op); end
      MA:   begin e.sa = 2; e.sb = 1; e.imm = op == 7'h23 ? 3'd1 : 3'd0; end
      MR:   e.adr = 1;
      MWB:  begin e.res = 1; e.rw = 1; e.done = 1; end
      MW:   begin e.adr = 1; e.memw = 1; e.done = rdy; end
      XR:   begin e.sa = 2; if (alu_ok(f3)) e.alu = alu_code(f3, ins[30]); else m.alu = 0; end
      XI: begin
        e.sa = 2; e.sb = 1;
        if (op == 7'h37) begin e.imm = 4; e.alu = 4; end
        else if (alu_ok(f3)) e.alu = alu_code(f3, 1'b0);
        else m.alu = 0;
      end
      AWB:  begin e.rw = 1; e.done = 1; end
      BR:   begin e.sa = 2; e.alu = 1; e.imm = 2; if (br_ok(f3)) begin e.pcw = taken(f3, z, lt); e.done = 1; end end
      JL:   begin e.sa = 1; e.sb = 2; e.pcw = 1; end
      JR:   begin e.sa = 2; e.sb = 1; e.res = 2; e.pcw = 1; end
      JRWB: begin e.sa = 1; e.sb = 2; e.res = 2; e.rw = 1; e.done = 1; end
      default: e.ill = 1;
    endcase
    if (rst) begin e.pcw = 0; e.irw = 0; e.memw = 0; e.rw = 0; end
  endfunction
  task automatic cycle(input step_t s, input logic [31:0] ins, input int n, output logic r);
    @(posedge clk);
    #1;
    rst_n = !rst_req;
    Instr = ins;
    Zero = zf < 0 ? 1'($urandom_range(0, 1)) : zf[0];
    alu_lt = 1'($urandom_range(0, 1));
    if (rnd) mem_ready = $urandom_range(0, 3) != 0;
    else if ((s == MR || s == MW) && hold > 0) begin mem_ready = 0; hold--; end
    else mem_ready = 1;
    cur = s;
    model(s, ins, Zero, alu_lt, mem_ready, !rst_n, exp_c, msk_c);
    lit_e = '0;
    lit_m = '0;
    foreach (lits[i]) if (lits[i].cyc == n) begin lit_e |= lits[i].e; lit_m |= lits[i].m; end
    exp_valid = 1;
    r = mem_ready;
  endtask
  task automatic run_instr(input logic [31:0] ins, output bit trapped);
    step_t q[$];
    int n = 0;
    logic r;
    logic [2:0] f3 = ins[14:12];
    q.push_back(F);
    q.push_back(D);
    case (ins[6:0])
      7'h03: begin q.push_back(MA); q.push_back(MR); q.push_back(MWB); end
      7'h23: begin q.push_back(MA); q.push_back(MW); end
      7'h33: begin q.push_back(XR); q.push_back(alu_ok(f3) ? AWB : TR); end
      7'h13: begin q.push_back(XI); q.push_back(alu_ok(f3) ? AWB : TR); end
      7'h37: begin q.push_back(XI); q.push_back(AWB); end
      7'h63: begin q.push_back(BR); if (!br_ok(f3)) q.push_back(TR); end
      7'h6f: begin q.push_back(JL); q.push_back(AWB); end
      7'h67: begin q.push_back(JR); q.push_back(JRWB); end
      default: q.push_back(TR);
    endcase
    foreach (q[i]) begin
      do begin n++; cycle(q[i], ins, n, r); end
      while ((q[i] == F || q[i] == MR || q[i] == MW) && !r);
    end
    trapped = q[$] == TR;
    lits.delete();
  endtask
  task automatic do_reset(input step_t s, input logic [31:0] ins, input int n);
    logic r;
    rst_req = 1;
    cycle(s, ins, n, r);
    rst_req = 0;
    lits.delete();
  endtask
  function automatic logic [31:0] gen();
    logic [6:0] ops [12] = '{7'h03, 7'h23, 7'h33, 7'h33, 7'h13, 7'h13, 7'h37, 7'h63, 7'h63, 7'h6f, 7'h67, 7'h00};
    logic [2:0] good [4] = '{3'd0, 3'd2, 3'd6, 3'd7};
    logic [31:0] w = $urandom;
    int k = $urandom_range(0, 12);
    if (k < 12) w[6:0] = ops[k];
    if ($urandom_range(0, 2) != 0) w[14:12] = good[$urandom_range(0, 3)];
    return w;
  endfunction
  initial begin
    ctl_t le, lm;
    logic r;
    bit trapped;
    rst_req = 1;
    cycle(X, 0, 0, r);
    cycle(X, 0, 0, r);
    rst_req = 0;
    le = '0; lm = '0; lm.ill = 1; lm.irw = 1; lm.sb = '1; le.irw = 1; le.sb = 2'd2; lits.push_back('{1, le, lm});
    le = '0; lm = '0; lm.alu = '1; lm.sa = '1; lm.sb = '1; le.sa = 2'd2; lits.push_back('{3, le, lm});
    le = '0; lm = '0; lm.rw = 1; lm.done = 1; le.rw = 1; le.done = 1; lits.push_back('{4, le, lm});
    run_instr(32'h002081B3, trapped);
    le = '0; lm = '0; lm.alu = '1; le.alu = 3'b001; lits.push_back('{3, le, lm});
    run_instr(32'h402081B3, trapped);
    hold = 2;
    le = '0; lm = '0; lm.adr = 1; le.adr = 1;
    lits.push_back('{4, le, lm}); lits.push_back('{5, le, lm}); lits.push_back('{6, le, lm});
    le = '0; lm = '0; lm.res = '1; lm.rw = 1; lm.done = 1; le.res = 2'b01; le.rw = 1; le.done = 1; lits.push_back('{7, le, lm});
    run_instr(32'h0040A283, trapped);
    hold = 2;
    le = '0; lm = '0; lm.imm = '1; le.imm = 3'b001; lits.push_back('{3, le, lm});
    le = '0; lm = '0; lm.memw = 1; lm.done = 1; le.memw = 1; lits.push_back('{4, le, lm});
    le = '0; lm = '0; lm.memw = 1; lm.done = 1; lm.rw = 1; le.memw = 1; le.done = 1; lits.push_back('{6, le, lm});
    run_instr(32'h0050A423, trapped);
    zf = 1;
    le = '0; lm = '0; lm.pcw = 1; lm.done = 1; le.pcw = 1; le.done = 1; lits.push_back('{3, le, lm});
    run_instr(32'h00208463, trapped);
    zf = 0;
    le = '0; lm = '0; lm.pcw = 1; lm.done = 1; le.done = 1; lits.push_back('{3, le, lm});
    run_instr(32'h00208463, trapped);
    zf = -1;
    le = '0; lm = '0; lm.ill = 1; le.ill = 1; lits.push_back('{3, le, lm});
    run_instr(32'h00000000, trapped);
    repeat (10) cycle(TR, 0, 0, r);
    do_reset(TR, 0, 0);
    le = '0; lm = '0; lm.ill = 1; lm.irw = 1; le.irw = 1; lits.push_back('{1, le, lm});
    run_instr(32'h002081B3, trapped);
    hold = 5;
    cycle(F, 32'h0050A423, 1, r);
    cycle(D, 32'h0050A423, 2, r);
    cycle(MA, 32'h0050A423, 3, r);
    cycle(MW, 32'h0050A423, 4, r);
    le = '0; lm = '0; lm.memw = 1; lm.adr = 1; le.adr = 1; lits.push_back('{5, le, lm});
    do_reset(MW, 32'h0050A423, 5);
    hold = 0;
    le = '0; lm = '0; lm.irw = 1; lm.adr = 1; lm.res = '1; le.irw = 1; le.res = 2'b10; lits.push_back('{1, le, lm});
    run_instr(32'h0000006F, trapped);
    rnd = 1;
    repeat (400) begin
      run_instr(gen(), trapped);
      if (trapped) begin
        repeat ($urandom_range(1, 4)) cycle(TR, Instr, 0, r);
        do_reset(TR, Instr, 0);
      end
    end
    @(negedge clk);
    #1;
    exp_valid = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Multicycle RV32I control FSM; next generation of the single-cycle decoder. One instruction takes 3–5 cycles.
- Drives a shared-ALU / single-memory datapath: PC, OldPC, IR, ALUOut and Data registers.
- Adds a memory ready handshake, an illegal-opcode trap, a retire strobe and widened control fields.

Parameters:
- ALUCTRL_W, 3, ALUControl width (min 3; upper bits zero).
- IMMSRC_W, 3, ImmSrc width (min 3; upper bits zero).
- MEM_HANDSHAKE, 1, 1 = honour mem_ready; 0 = memory assumed single-cycle (mem_ready ignored, treated as 1).

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- Instr  in  32  IR contents (valid from DECODE onward)
- Zero  in  1  ALU zero flag
- alu_lt  in  1  ALU signed less-than flag (used only with BRANCH_EXT_EN)
- mem_ready  in  1  memory access completes this cycle
- PCWrite  out  1  PC register enable
- AdrSrc  out  1  0 = PC, 1 = ALUOut
- MemWrite  out  1  memory write strobe
- IRWrite  out  1  IR and OldPC enable
- ResultSrc  out  2  00 = ALUOut, 01 = Data, 10 = ALUResult
- ALUSrcA  out  2  00 = PC, 01 = OldPC, 10 = RD1
- ALUSrcB  out  2  00 = RD2, 01 = ImmExt, 10 = 4
- RegWrite  out  1  register-file write
- ALUControl  out  ALUCTRL_W  000 add, 001 sub, 010 and, 011 or, 101 slt, 100 pass-B
- ImmSrc  out  IMMSRC_W  000 I, 001 S, 010 B, 011 J, 100 U
- instr_done  out  1  one-cycle pulse on the instruction's final cycle
- illegal_instr  out  1  sticky trap flag

Behaviour:
- State register only. All outputs are combinational from state, Instr, Zero, alu_lt and mem_ready. Unlisted outputs default to 0; ALUControl defaults to add.
- Reset: when rst_n is low at a clock edge, state becomes FETCH and illegal_instr clears. While rst_n is low, PCWrite, IRWrite, MemWrite and RegWrite are forced to 0.
- FETCH:
  - AdrSrc=0, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10.
  - IRWrite and PCWrite equal mem_ready.
  - Stay in FETCH until mem_ready, then go to DECODE.
- DECODE:
  - ALUSrcA=01, ALUSrcB=01, add, ImmSrc per opcode (branch/jump target into ALUOut).
  - Next state by opcode: 0000011 or 0100011 → MEMADR; 0110011 → EXECR; 0010011 or 0110111 → EXECI; 1100011 → BRANCH; 1101111 → JAL; 1100111 → JALR; anything else → TRAP.
- MEMADR: ALUSrcA=10, ALUSrcB=01, add, ImmSrc I (load) or S (store). Next: load → MEMREAD, store → MEMWRITE.
- MEMREAD: AdrSrc=1. Hold until mem_ready, then → MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1, instr_done=1. → FETCH.
- MEMWRITE: AdrSrc=1, MemWrite=1 held until mem_ready. On that cycle instr_done=1 and → FETCH.
- EXECR:
  - ALUSrcA=10, ALUSrcB=00.
  - funct3 000 → sub if funct7[5]=1, else add; 110 → or; 111 → and; 010 → slt; other funct3 → TRAP.
  - Next: ALUWB.
- EXECI:
  - ALUSrcA=10, ALUSrcB=01.
  - LUI: ImmSrc U, pass-B.
  - Otherwise ImmSrc I; funct3 000 → add, 110 → or, 111 → and, 010 → slt; other funct3 → TRAP.
  - Next: ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1, instr_done=1. → FETCH.
- BRANCH:
  - ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, ImmSrc B.
  - beq: PCWrite=Zero.
  - instr_done=1, → FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1. → ALUWB.
- JALR:
  - Cycle 1: ALUSrcA=10, ALUSrcB=01, add, ResultSrc=10, PCWrite=1, ImmSrc I. → JALRWB.
  - JALRWB: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=10, RegWrite=1, instr_done=1. → FETCH.
- TRAP: all strobes 0, illegal_instr=1. Stays in TRAP until reset.
- Latency: R/I/LUI/JAL/JALR 4 cycles; lw 5; sw 4; branch 3 (each +N wait cycles on mem_ready).
- mem_ready outside FETCH, MEMREAD and MEMWRITE is ignored.

Optional Feature:
- BRANCH_EXT_EN defined: BRANCH also decodes bne (PCWrite=~Zero), blt (PCWrite=alu_lt) and bge (PCWrite=~alu_lt), all using sub.
- Undefined: any B-type funct3 other than 000 → TRAP, and alu_lt is unused.

Decomposition:
- Package riscv_ctrl_pkg holds:
  - state enum;
  - opcode constants;
  - ALUControl, ImmSrc, ResultSrc and ALUSrc encodings.
- Sub-module alu_decoder: combinational (opcode class, funct3, funct7[5]) → ALUControl plus an illegal flag. Used by EXECR and EXECI.

Test Plan:
- 0x002081B3 (add x3,x1,x2), mem_ready=1 → states FETCH, DECODE, EXECR, ALUWB; ALUControl=000 in EXECR; RegWrite and instr_done in cycle 4 only.
- 0x402081B3 (sub) → ALUControl=001 in EXECR; 0x0040A283 (lw) with mem_ready low 2 cycles in MEMREAD → 7 cycles total, AdrSrc=1 throughout MEMREAD.
- 0x0050A423 (sw) → ImmSrc=001 in MEMADR; MemWrite held until mem_ready; no RegWrite.
- 0x00208463 (beq): Zero=1 → PCWrite=1 in BRANCH; Zero=0 → PCWrite=0; 3 cycles total.
- 0x00000000 → TRAP after DECODE, illegal_instr=1 and no strobes for 10 cycles; rst_n low one cycle → FETCH, illegal_instr=0.
- rst_n dropped during MEMWRITE with mem_ready=0 → MemWrite=0 in that cycle, state=FETCH next cycle.
